// File: rtl/console_rx_if.sv
// Bus device port shared by the RAM, console and console_rx devices.
//   req   : device request from the bus
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : write data
//   rdata : read data returned by the device
// master drives the request side, slave (the device) returns rdata.
interface console_rx_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic                    req;
  logic                    we;
  logic [AddressWidth-1:0] addr;
  logic [DataWidth-1:0]    wdata;
  logic [DataWidth-1:0]    rdata;

  modport master (output req, we, addr, wdata, input rdata);
  modport slave  (input req, we, addr, wdata, output rdata);
endinterface

// File: rtl/console_rx.sv
// console_rx: 8N1 UART receiver with an 8-entry byte FIFO, exposed to the host
// as a bus device (RXDATA / STATUS / CTRL registers on addr[3:2]).
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous reset, active high
//   bus    : device port (req/we/addr/wdata in, registered rdata out)
//   rx_i   : serial input, idle high, asynchronous to clk_i
//   irq_o  : registered, high while FIFO non-empty or an error flag is set
//
// Receive FSM states:
//   state        | meaning
//   ST_IDLE      | line idle, waiting for rx_s low
//   ST_START     | half-bit wait, re-check start bit at its centre
//   ST_DATA      | sampling 8 data bits at bit centres, LSB first
//   ST_STOP      | waiting for stop-bit centre, then push or flag frame error
//   ST_WAIT_HIGH | after a framing error, wait for line to return high
module console_rx #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int ClkPerBit    = 16,
  parameter int FifoDepth    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  console_rx_if.slave   bus,
  input  logic          rx_i,
  output logic          irq_o
);

  localparam int CntW   = $clog2(ClkPerBit);
  localparam int PtrW   = $clog2(FifoDepth);
  localparam int CountW = PtrW + 1;

  localparam logic [CntW-1:0]   HalfBit = CntW'(ClkPerBit / 2 - 1);
  localparam logic [CntW-1:0]   FullBit = CntW'(ClkPerBit - 1);
  localparam logic [CountW-1:0] Depth   = CountW'(FifoDepth);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_e;

  logic                 rx_meta_q, rx_s_q;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           mem_q [FifoDepth];
  logic [7:0]           mem_d [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]    count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 irq_q, irq_d;

  logic       push_req, frame_set;
  logic       rd_req, wr_req, not_empty, full, pop, clr, flush, push_ok, ovr_set;
  logic [1:0] reg_sel;
  logic       unused_bus_bits;

  assign unused_bus_bits = ^{bus.addr[AddressWidth-1:4], bus.addr[1:0],
                             bus.wdata[DataWidth-1:2]};

  // Receive FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = HalfBit;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = ST_DATA;
            cnt_d   = FullBit;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = FullBit;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register access and FIFO
  always_comb begin
    rd_req    = bus.req & ~bus.we;
    wr_req    = bus.req & bus.we;
    reg_sel   = bus.addr[3:2];
    not_empty = (count_q != '0);
    full      = (count_q == Depth);
    pop       = rd_req & (reg_sel == 2'd0) & not_empty;
    clr       = wr_req & (reg_sel == 2'd2) & bus.wdata[0];
    flush     = wr_req & (reg_sel == 2'd2) & bus.wdata[1];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok   = push_req & ~flush & (~full | pop);
    ovr_set   = push_req & ~flush & full & ~pop;

    rdata_d = rdata_q;
    if (rd_req) begin
      rdata_d = '0;
      unique case (reg_sel)
        2'd0: if (not_empty) rdata_d[7:0] = mem_q[rd_ptr_q];
        2'd1: begin
          rdata_d[0]          = not_empty;
          rdata_d[1]          = overrun_q;
          rdata_d[2]          = frame_err_q;
          rdata_d[8 +: CountW] = count_q;
        end
        default: rdata_d = '0;
      endcase
    end

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = shift_q;

    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CountW'(push_ok) - CountW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Set beats clear when both land in the same cycle.
    overrun_d   = ovr_set   ? 1'b1 : (clr ? 1'b0 : overrun_q);
    frame_err_d = frame_set ? 1'b1 : (clr ? 1'b0 : frame_err_q);

    irq_d = not_empty | overrun_q | frame_err_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_console_rx.sv
module tb_console_rx;
  localparam int ClkPerBit = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic irq;

  console_rx_if bus ();

  console_rx dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave),
    .rx_i  (rx),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue plus two sticky flags.
  logic [7:0] model_q[$];
  bit         m_ovr = 1'b0;
  bit         m_fe  = 1'b0;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = 32'h0;
    s[0]    = (model_q.size() != 0);
    s[1]    = m_ovr;
    s[2]    = m_fe;
    s[15:8] = 8'(model_q.size());
    return s;
  endfunction

  function automatic logic model_irq();
    return (model_q.size() != 0) | m_ovr | m_fe;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop_hi);
    if (!stop_hi)              m_fe = 1'b1;
    else if (model_q.size() < 8) model_q.push_back(b);
    else                       m_ovr = 1'b1;
  endfunction

  function automatic logic [31:0] model_pop();
    if (model_q.size() == 0) return 32'h0;
    return {24'h0, model_q.pop_front()};
  endfunction

  function automatic void model_ctrl(input logic [31:0] w);
    if (w[0]) begin m_ovr = 1'b0; m_fe = 1'b0; end
    if (w[1]) model_q.delete();
  endfunction

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = {28'h0, a, 2'b00}; bus.wdata = 32'h0;
    @(posedge clk); #1;
    bus.req = 1'b0;
    d = bus.rdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] w);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = {28'h0, a, 2'b00}; bus.wdata = w;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic hold_bit();
    repeat (ClkPerBit) @(posedge clk);
    #1;
  endtask

  // One frame on rx; with stop_hi=0 the line stays low for 'hold' more cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int hold);
    @(posedge clk); #1;
    rx = 1'b0; hold_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; hold_bit();
    end
    rx = stop_hi; hold_bit();
    if (!stop_hi) begin
      repeat (hold) @(posedge clk);
      #1 rx = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop_hi, input int hold);
    send_frame(b, stop_hi, hold);
    model_frame(b, stop_hi);
  endtask

  task automatic rd_data(input string name);
    logic [31:0] d, e;
    e = model_pop();
    bus_read(2'd0, d);
    check(name, d, e);
  endtask

  task automatic rd_status(input string name);
    logic [31:0] d;
    bus_read(2'd1, d);
    check(name, d, model_status());
  endtask

  task automatic wr_ctrl(input logic [31:0] w);
    bus_write(2'd2, w);
    model_ctrl(w);
  endtask

  task automatic check_irq(input string name);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(name, {31'h0, irq}, {31'h0, model_irq()});
  endtask

  // Frame whose stop-bit push lands on the same edge as an RXDATA read.
  // Push edge is 155 edges after the start bit is driven: 2 sync + 1 IDLE
  // + 8 START + 8*16 DATA + 16 STOP.
  task automatic frame_with_read(input logic [7:0] b, output logic [31:0] d);
    fork
      send_frame(b, 1'b1, 0);
      begin
        repeat (154) @(posedge clk);
        bus_read(2'd0, d);
      end
    join
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, e;
    int op;

    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;

    tbl[0]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0201};
    tbl[1]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
    tbl[2]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    tbl[3]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};
    tbl[4]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0201};
    tbl[5]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    tbl[6]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    tbl[7]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0011};
    tbl[8]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0101};
    tbl[9]  = '{1'b1, 2'd2, 32'h2,        32'h0};
    tbl[10] = '{1'b0, 2'd1, 32'h0,        32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    rd_status("reset_status");

    // Single byte 0xA5
    rx_frame(8'hA5, 1'b1, 0);
    @(negedge clk);
    check("a5_irq", {31'h0, irq}, 32'h1);
    bus_read(2'd1, d);
    check("a5_status", d, 32'h0000_0101);
    rd_data("a5_data");
    check_irq("a5_irq_clear");
    rd_status("a5_status_empty");

    // Register table on a FIFO holding 0x11, 0x22
    rx_frame(8'h11, 1'b1, 0);
    rx_frame(8'h22, 1'b1, 0);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata);
      else begin
        bus_read(tbl[i].addr, d);
        check($sformatf("tbl[%0d]", i), d, tbl[i].exp);
      end
    end
    model_q.delete();

    // Overrun: 0x01..0x09 with no reads
    for (int i = 1; i <= 9; i++) rx_frame(8'(i), 1'b1, 0);
    bus_read(2'd1, d);
    check("ovr_status", d, 32'h0000_0803);
    for (int i = 0; i < 9; i++) rd_data($sformatf("ovr_read%0d", i));
    rd_status("ovr_status_after");
    wr_ctrl(32'h1);
    rd_status("ovr_cleared");

    // Frame error with long low line; a retrigger would push after the rise
    rx_frame(8'h3C, 1'b0, 200);
    repeat (200) @(posedge clk);
    rd_status("fe_status");
    check_irq("fe_irq");
    wr_ctrl(32'h1);
    rd_status("fe_cleared");
    check_irq("fe_irq_clear");

    // Start-bit glitch
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    rd_status("glitch_status");
    rx_frame(8'h42, 1'b1, 0);
    rd_data("glitch_next_frame");

    // Read coinciding with push, FIFO holding one byte
    rx_frame(8'h33, 1'b1, 0);
    frame_with_read(8'h7E, d);
    e = model_pop();
    model_frame(8'h7E, 1'b1);
    check("simul_old_head", d, e);
    rd_status("simul_status");
    rd_data("simul_new_byte");

    // Read coinciding with push on a full FIFO: no overrun
    for (int i = 0; i < 8; i++) rx_frame(8'hB0 + 8'(i), 1'b1, 0);
    frame_with_read(8'hC3, d);
    e = model_pop();
    model_frame(8'hC3, 1'b1);
    check("full_pop_head", d, e);
    rd_status("full_pop_status");
    wr_ctrl(32'h2);
    rd_status("flush_status");

    // Asynchronous reset in the middle of DATA of 0xF0 (upper bits high)
    rx_frame(8'h99, 1'b1, 0);
    rd_status("pre_reset_status");
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        repeat (40) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_rdata", bus.rdata, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        repeat (50) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    model_q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    repeat (20) @(posedge clk);
    rd_status("midrst_no_push");
    rx_frame(8'h55, 1'b1, 0);
    bus_read(2'd1, d);
    check("post_rst_status", d, 32'h0000_0101);
    rd_data("post_rst_data");

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 3)      rx_frame(8'($urandom), 1'b1, 0);
      else if (op == 4) rx_frame(8'($urandom), 1'b0, $urandom_range(1, 30));
      else if (op <= 6) rd_data($sformatf("rnd%0d_data", n));
      else if (op <= 8) rd_status($sformatf("rnd%0d_status", n));
      else              wr_ctrl({30'h0, 2'($urandom)});
      check_irq($sformatf("rnd%0d_irq", n));
    end
    rd_status("rnd_final_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
